// File: rtl/lcd_cmd_sched_if.sv
// Interface bundling the host push channel and the LCD_CTRL command channel
// for lcd_cmd_sched. The scheduler uses the master modport. The host and
// LCD_CTRL side uses the slave modport.
interface lcd_cmd_sched_if #(
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push_valid;
  logic [3:0]       push_cmd;
  logic             push_ready;
  logic             push_illegal;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       lcd_cmd;
  logic             lcd_cmd_valid;
  logic             lcd_busy;
  logic             lcd_done;
  logic             finished;
  logic             timeout_err;

  modport master (
    input  push_valid, push_cmd, lcd_busy, lcd_done,
    output push_ready, push_illegal, fifo_count, lcd_cmd, lcd_cmd_valid,
           finished, timeout_err
  );

  modport slave (
    output push_valid, push_cmd, lcd_busy, lcd_done,
    input  push_ready, push_illegal, fifo_count, lcd_cmd, lcd_cmd_valid,
           finished, timeout_err
  );
endinterface

// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: host-side command scheduler for LCD_CTRL.
// Buffers 4-bit commands in a circular FIFO. It issues one command per LCD_CTRL
// busy window, and only while LCD_CTRL is idle. It stops for good once the
// write command (0) has been followed by lcd_done.
// Optional feature: define LCD_SCHED_TIMEOUT_EN to add a watchdog. The
// watchdog counts cycles spent in WAIT or FINISH. After TO_CYCLES cycles it
// sets timeout_err and forces the FSM into DONE.
module lcd_cmd_sched #(
  parameter int DEPTH     = 8,
  parameter int TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  lcd_cmd_sched_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TO_CYCLES < 2) begin : g_param_check
    $error("lcd_cmd_sched: DEPTH must be a power of 2 >= 2 and TO_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    GUARD  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, ready, push_acc, push_ok, pop;
  logic          timeout_hit;
  logic          cmd_valid_c;
  logic [3:0]    lcd_cmd_q;
  logic          push_illegal_q, finished_q, timeout_err_q;

  // ready is forced low during reset and once the FSM reaches DONE.
  // DONE freezes the FIFO.
  assign full     = (count == CW'(DEPTH));
  assign ready    = !reset && (state != DONE) && !full;
  assign push_acc = bus.push_valid && ready;
  // Codes C-F are accepted, so the host never stalls on them, but they are not stored.
  assign push_ok  = push_acc && (bus.push_cmd <= 4'hB);
  assign pop      = (state == IDLE) && !bus.lcd_busy && (count != '0);

`ifdef LCD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = ((state == WAIT) || (state == FINISH)) &&
                       (to_cnt == TW'(TO_CYCLES - 1));

  // Watchdog counter: restarts on every state change and advances while in WAIT or FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state_next != state) begin
      to_cnt <= '0;
    end else if ((state == WAIT) || (state == FINISH)) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and command strobe. The strobe is a pure decode of ISSUE, so it lasts exactly one cycle.
  always_comb begin
    state_next  = state;
    cmd_valid_c = 1'b0;
    unique case (state)
      IDLE:    if (pop) state_next = ISSUE;
      ISSUE: begin
        cmd_valid_c = 1'b1;
        state_next  = (lcd_cmd_q == 4'h0) ? FINISH : GUARD;
      end
      GUARD:   state_next = WAIT;
      WAIT:    if (!bus.lcd_busy) state_next = IDLE;
      FINISH:  if (bus.lcd_done) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = DONE;
  end

  // FIFO storage holds data only, so it has no reset. Stale entries are unreachable behind the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.push_cmd;
  end

  // Control state: FSM, FIFO pointers and count, issued command, and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      lcd_cmd_q      <= 4'h0;
      push_illegal_q <= 1'b0;
      finished_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        lcd_cmd_q <= mem[rd_ptr];
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      push_illegal_q <= push_acc && (bus.push_cmd > 4'hB);
      if ((state == FINISH) && bus.lcd_done && !timeout_hit) finished_q <= 1'b1;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign bus.push_ready    = ready;
  assign bus.push_illegal  = push_illegal_q;
  assign bus.fifo_count    = count;
  assign bus.lcd_cmd       = lcd_cmd_q;
  assign bus.lcd_cmd_valid = cmd_valid_c;
  assign bus.finished      = finished_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Testbench for lcd_cmd_sched. A vector table covers single-cycle behaviour,
// and hand-written sequences cover boot hold, FIFO full, finish, mid-run
// reset and the watchdog.
module tb_lcd_cmd_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;

  lcd_cmd_sched_if #(.DEPTH(8)) bus ();

  lcd_cmd_sched #(.DEPTH(8), .TO_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pv;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic       rdy;
    logic       ill;
    int         cnt;
    logic       vld;
    logic [3:0] cmd;
    logic       fin;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [3:0] pc, input logic busy, input logic done);
    bus.push_valid = pv;
    bus.push_cmd   = pc;
    bus.lcd_busy   = busy;
    bus.lcd_done   = done;
  endtask

  task automatic do_reset(input string tag, input logic busy);
    reset = 1'b1;
    drive(1'b0, 4'h0, busy, 1'b0);
    tick();
    tick();
    chk({tag, "_rst_ready"}, bus.push_ready, 0);
    chk({tag, "_rst_count"}, bus.fifo_count, 0);
    chk({tag, "_rst_valid"}, bus.lcd_cmd_valid, 0);
    chk({tag, "_rst_fin"}, bus.finished, 0);
    chk({tag, "_rst_to"}, bus.timeout_err, 0);
    reset = 1'b0;
  endtask

  // Tick until lcd_cmd_valid is seen, or give up after 10 cycles.
  task automatic wait_issue(input string tag, output logic [3:0] c, output int n);
    n = 0;
    while (!bus.lcd_cmd_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_issue_seen"}, bus.lcd_cmd_valid, 1);
    c = bus.lcd_cmd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "bench watchdog");
  end

  initial begin
    logic [3:0] c;
    int         n;
    int         seen;
    logic [3:0] got[$];

    drive(1'b0, 4'h0, 1'b0, 1'b0);

    //            pv   pc    busy done  rdy  ill  cnt vld  cmd   fin
    vt.push_back('{1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'h0, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'h0, 1'b0});
    vt.push_back('{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'h0, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 4'h3, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'h3, 1'b0});
    vt.push_back('{1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'h3, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'h3, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'h3, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 4'hA, 1'b0});
    vt.push_back('{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'hA, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'hA, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'hA, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 4'hB, 1'b0});
    vt.push_back('{1'b1, 4'hD, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'hB, 1'b0});
    vt.push_back('{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'hB, 1'b0});
    vt.push_back('{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 4'hB, 1'b0});
    vt.push_back('{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 4'h5, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 4'h5, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 4'h5, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 4'h5, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 4'h6, 1'b0});

    // Vector table: latency, issue spacing, illegal codes, simultaneous push/pop
    do_reset("vec", 1'b0);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].pv, vt[i].pc, vt[i].busy, vt[i].done);
      tick();
      chk($sformatf("v%0d_ready", i), bus.push_ready, vt[i].rdy);
      chk($sformatf("v%0d_illegal", i), bus.push_illegal, vt[i].ill);
      chk($sformatf("v%0d_count", i), bus.fifo_count, vt[i].cnt);
      chk($sformatf("v%0d_valid", i), bus.lcd_cmd_valid, vt[i].vld);
      chk($sformatf("v%0d_cmd", i), bus.lcd_cmd, vt[i].cmd);
      chk($sformatf("v%0d_fin", i), bus.finished, vt[i].fin);
    end

    // Boot hold: busy high for 70 cycles, then one issue per busy window
    do_reset("t1", 1'b1);
    drive(1'b1, 4'h3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'h9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    seen = 0;
    repeat (68) begin
      tick();
      if (bus.lcd_cmd_valid) seen = 1;
    end
    chk("t1_no_issue_while_busy", seen, 0);
    chk("t1_count", bus.fifo_count, 2);
    bus.lcd_busy = 1'b0;
    wait_issue("t1a", c, n);
    chk("t1_first_latency", n, 1);
    chk("t1_first_cmd", c, 3);
    bus.lcd_busy = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.lcd_cmd_valid) seen = 1;
    end
    chk("t1_no_second_in_window", seen, 0);
    bus.lcd_busy = 1'b0;
    wait_issue("t1b", c, n);
    chk("t1_second_latency", n, 2);
    chk("t1_second_cmd", c, 9);

    // Full FIFO: eight pushes fill it, the ninth is dropped, order is kept
    do_reset("t2", 1'b1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t2_count_full", bus.fifo_count, 8);
    chk("t2_ready_full", bus.push_ready, 0);
    drive(1'b1, 4'h9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t2_count_after_9th", bus.fifo_count, 8);
    got.delete();
    repeat (60) begin
      tick();
      if (bus.lcd_cmd_valid) got.push_back(bus.lcd_cmd);
    end
    chk("t2_issue_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_order%0d", i), (i < got.size()) ? int'(got[i]) : -1, i + 1);
    end
    chk("t2_count_empty", bus.fifo_count, 0);

    // Write command ends the run once lcd_done arrives
    do_reset("t4", 1'b0);
    drive(1'b1, 4'h5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    wait_issue("t4a", c, n);
    chk("t4_first_cmd", c, 5);
    tick();
    wait_issue("t4b", c, n);
    chk("t4_write_cmd", c, 0);
    repeat (70) tick();
    chk("t4_fin_before_done", bus.finished, 0);
    bus.lcd_done = 1'b1;
    tick();
    bus.lcd_done = 1'b0;
    chk("t4_finished", bus.finished, 1);
    chk("t4_ready_done", bus.push_ready, 0);
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.lcd_cmd_valid) seen = 1;
    end
    chk("t4_no_issue_after_done", seen, 0);
    chk("t4_count_frozen", bus.fifo_count, 0);
    chk("t4_finished_sticky", bus.finished, 1);

    // Asynchronous reset while waiting with three commands queued
    do_reset("t5", 1'b0);
    drive(1'b1, 4'h4, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    wait_issue("t5", c, n);
    drive(1'b1, 4'h1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'h2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'h3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t5_count_pre", bus.fifo_count, 3);
    chk("t5_cmd_pre", bus.lcd_cmd, 4);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_count", bus.fifo_count, 0);
    chk("t5_async_cmd", bus.lcd_cmd, 0);
    chk("t5_async_ready", bus.push_ready, 0);
    chk("t5_async_valid", bus.lcd_cmd_valid, 0);
    chk("t5_async_fin", bus.finished, 0);
    tick();
    reset = 1'b0;
    bus.lcd_busy = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.lcd_cmd_valid) seen = 1;
    end
    chk("t5_fifo_discarded", seen, 0);
    chk("t5_ready_after", bus.push_ready, 1);

    // Watchdog on a stuck busy
    do_reset("t6", 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    wait_issue("t6", c, n);
    bus.lcd_busy = 1'b1;
    tick();
    tick();
`ifdef LCD_SCHED_TIMEOUT_EN
    repeat (15) tick();
    chk("t6_to_before", bus.timeout_err, 0);
    tick();
    chk("t6_to_set", bus.timeout_err, 1);
    chk("t6_fin", bus.finished, 0);
    chk("t6_ready", bus.push_ready, 0);
`else
    repeat (40) tick();
    chk("t6_no_timeout", bus.timeout_err, 0);
    chk("t6_ready", bus.push_ready, 1);
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    wait_issue("t6b", c, n);
    chk("t6_next_cmd", c, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
